// File: rtl/prog_result_checker.sv
// End-of-program result checker: waits for a PC halt or timeout, then compares
// a table of architectural registers. Optional macro RESULT_CHECK_MASK_EN adds per-entry compare masks.
module prog_result_checker #(
  parameter  int XLEN           = 32,
  parameter  int NUM_CHECKS     = 8,
  parameter  int TIMEOUT_CYCLES = 1000,
  parameter  int HALT_STABLE    = 4,
  localparam int IDX_W          = $clog2(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             exp_wr_en,
  input  logic [IDX_W-1:0] exp_wr_idx,
  input  logic [4:0]       exp_wr_reg,
  input  logic [XLEN-1:0]  exp_wr_val,
  input  logic             exp_wr_vld,
`ifdef RESULT_CHECK_MASK_EN
  input  logic [XLEN-1:0]  exp_wr_mask,
`endif
  output logic [4:0]       rf_rd_addr,
  input  logic [XLEN-1:0]  rf_rd_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [IDX_W:0]   fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [XLEN-1:0]  first_fail_val
);

  localparam int CYC_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int STB_W = $clog2(HALT_STABLE) + 1;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CYC_W-1:0]  cycle_cnt_reg, cycle_cnt_next;
  logic [STB_W-1:0]  stable_cnt_reg, stable_cnt_next;
  logic [XLEN-1:0]   last_pc_reg, last_pc_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              timed_out_reg, timed_out_next;
  logic [IDX_W:0]    fail_count_reg, fail_count_next;
  logic [IDX_W-1:0]  first_fail_idx_reg, first_fail_idx_next;
  logic [XLEN-1:0]   first_fail_val_reg, first_fail_val_next;

  logic              tbl_vld_reg  [NUM_CHECKS];
  logic [4:0]        tbl_rnum_reg [NUM_CHECKS];
  logic [XLEN-1:0]   tbl_val_reg  [NUM_CHECKS];
`ifdef RESULT_CHECK_MASK_EN
  logic [XLEN-1:0]   tbl_mask_reg [NUM_CHECKS];
`endif

  logic                  tbl_open;
  logic [NUM_CHECKS-1:0] entry_we;
  logic                  pc_eq;
  logic                  halt_hit;
  logic                  timeout_hit;
  logic [XLEN-1:0]       diff;
  logic                  mismatch;

  // The table is writable only while no run is in progress.
  assign tbl_open = (state_reg == IDLE) || (state_reg == DONE);

  generate
    for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_we
      assign entry_we[gi] = exp_wr_en && tbl_open && (exp_wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_vld_reg[i]  <= 1'b0;
        tbl_rnum_reg[i] <= '0;
        tbl_val_reg[i]  <= '0;
`ifdef RESULT_CHECK_MASK_EN
        tbl_mask_reg[i] <= '1;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (entry_we[i]) begin
          tbl_vld_reg[i]  <= exp_wr_vld;
          tbl_rnum_reg[i] <= exp_wr_reg;
          tbl_val_reg[i]  <= exp_wr_val;
`ifdef RESULT_CHECK_MASK_EN
          tbl_mask_reg[i] <= exp_wr_mask;
`endif
        end
      end
    end
  end

`ifdef RESULT_CHECK_MASK_EN
  assign diff = (rf_rd_data ^ tbl_val_reg[idx_reg]) & tbl_mask_reg[idx_reg];
`else
  assign diff = rf_rd_data ^ tbl_val_reg[idx_reg];
`endif

  assign mismatch    = (state_reg == CHECK) && tbl_vld_reg[idx_reg] && (diff != '0);
  assign pc_eq       = (pc_in == last_pc_reg);
  // The compare that lifts the run length to HALT_STABLE samples is the halt.
  assign halt_hit    = pc_eq && (stable_cnt_reg == STB_W'(HALT_STABLE - 2));
  assign timeout_hit = (cycle_cnt_reg == CYC_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next          = state_reg;
    cycle_cnt_next      = cycle_cnt_reg;
    stable_cnt_next     = stable_cnt_reg;
    last_pc_next        = last_pc_reg;
    idx_next            = idx_reg;
    timed_out_next      = timed_out_reg;
    fail_count_next     = fail_count_reg;
    first_fail_idx_next = first_fail_idx_reg;
    first_fail_val_next = first_fail_val_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next          = RUN;
          cycle_cnt_next      = '0;
          stable_cnt_next     = '0;
          last_pc_next        = pc_in;
          idx_next            = '0;
          timed_out_next      = 1'b0;
          fail_count_next     = '0;
          first_fail_idx_next = '0;
          first_fail_val_next = '0;
        end
      end
      RUN: begin
        cycle_cnt_next  = cycle_cnt_reg + 1'b1;
        stable_cnt_next = pc_eq ? stable_cnt_reg + 1'b1 : '0;
        last_pc_next    = pc_in;
        if (halt_hit) begin
          state_next     = CHECK;
          idx_next       = '0;
          timed_out_next = 1'b0;
        end else if (timeout_hit) begin
          state_next     = CHECK;
          idx_next       = '0;
          timed_out_next = 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          fail_count_next = fail_count_reg + 1'b1;
          if (fail_count_reg == '0) begin
            first_fail_idx_next = idx_reg;
            first_fail_val_next = rf_rd_data;
          end
        end
        if (idx_reg == IDX_W'(NUM_CHECKS - 1)) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg          <= IDLE;
      cycle_cnt_reg      <= '0;
      stable_cnt_reg     <= '0;
      last_pc_reg        <= '0;
      idx_reg            <= '0;
      timed_out_reg      <= 1'b0;
      fail_count_reg     <= '0;
      first_fail_idx_reg <= '0;
      first_fail_val_reg <= '0;
    end else begin
      state_reg          <= state_next;
      cycle_cnt_reg      <= cycle_cnt_next;
      stable_cnt_reg     <= stable_cnt_next;
      last_pc_reg        <= last_pc_next;
      idx_reg            <= idx_next;
      timed_out_reg      <= timed_out_next;
      fail_count_reg     <= fail_count_next;
      first_fail_idx_reg <= first_fail_idx_next;
      first_fail_val_reg <= first_fail_val_next;
    end
  end

  assign rf_rd_addr     = (state_reg == CHECK) ? tbl_rnum_reg[idx_reg] : 5'd0;
  assign busy           = (state_reg == RUN) || (state_reg == CHECK);
  assign done           = (state_reg == DONE);
  assign pass           = (state_reg == DONE) && (fail_count_reg == '0);
  assign timed_out      = timed_out_reg;
  assign fail_count     = fail_count_reg;
  assign first_fail_idx = first_fail_idx_reg;
  assign first_fail_val = first_fail_val_reg;

endmodule

// File: tb/tb_prog_result_checker.sv
// Self-checking bench for prog_result_checker: directed PC patterns, reset
// and mask corner cases, and randomized runs against a behavioural model.
module tb_prog_result_checker;
  localparam int XLEN           = 32;
  localparam int NUM_CHECKS     = 8;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int HALT_STABLE    = 4;
  localparam int IDX_W          = $clog2(NUM_CHECKS);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [XLEN-1:0]  pc_in = '0;
  logic             exp_wr_en = 1'b0;
  logic [IDX_W-1:0] exp_wr_idx = '0;
  logic [4:0]       exp_wr_reg = '0;
  logic [XLEN-1:0]  exp_wr_val = '0;
  logic             exp_wr_vld = 1'b0;
`ifdef RESULT_CHECK_MASK_EN
  logic [XLEN-1:0]  exp_wr_mask = '1;
`endif
  logic [4:0]       rf_rd_addr;
  logic [XLEN-1:0]  rf_rd_data;
  logic             busy, done, pass, timed_out;
  logic [IDX_W:0]   fail_count;
  logic [IDX_W-1:0] first_fail_idx;
  logic [XLEN-1:0]  first_fail_val;

  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] pc_seq [256];
  logic            m_vld  [NUM_CHECKS];
  logic [4:0]      m_rnum [NUM_CHECKS];
  logic [XLEN-1:0] m_val  [NUM_CHECKS];
  logic [XLEN-1:0] m_mask [NUM_CHECKS];

  int n_assert = 0;
  int n_fail   = 0;

  assign rf_rd_data = rf[rf_rd_addr];

  always #5 clk = ~clk;

  prog_result_checker #(
    .XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .HALT_STABLE(HALT_STABLE)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .pc_in(pc_in),
    .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx), .exp_wr_reg(exp_wr_reg),
    .exp_wr_val(exp_wr_val), .exp_wr_vld(exp_wr_vld),
`ifdef RESULT_CHECK_MASK_EN
    .exp_wr_mask(exp_wr_mask),
`endif
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_val(first_fail_val)
  );

  typedef struct {
    int a;        // leading samples of the start PC
    int inc;      // then this many incrementing samples, then parked forever
    int exp_len;  // RUN cycles until CHECK
    bit exp_to;
  } pc_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_pc(input int a, input int inc);
    for (int k = 0; k < 256; k++) begin
      if (k < a) pc_seq[k] = 32'h100;
      else if (k < a + inc) pc_seq[k] = 32'h100 + 32'(4 * (k - a + 1));
      else pc_seq[k] = 32'h800;
    end
  endtask

  // Halt = HALT_STABLE equal consecutive samples (start sample included).
  task automatic model_run(output int len, output bit to);
    int  run;
    bit  found;
    run = 1; found = 0; len = TIMEOUT_CYCLES; to = 1'b1;
    for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
      if (!found) begin
        run = (pc_seq[i] == pc_seq[i-1]) ? run + 1 : 1;
        if (run >= HALT_STABLE) begin
          found = 1; len = i; to = 1'b0;
        end
      end
    end
  endtask

  task automatic model_expect(output int fc, output int fi, output logic [XLEN-1:0] fv);
    fc = 0; fi = 0; fv = '0;
    for (int j = 0; j < NUM_CHECKS; j++) begin
      if (m_vld[j] && (((rf[m_rnum[j]] ^ m_val[j]) & m_mask[j]) != '0)) begin
        if (fc == 0) begin fi = j; fv = rf[m_rnum[j]]; end
        fc++;
      end
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < NUM_CHECKS; j++) begin
      m_vld[j] = 1'b0; m_rnum[j] = '0; m_val[j] = '0; m_mask[j] = '1;
    end
  endtask

  task automatic write_entry(input int idx, input int rnum, input logic [XLEN-1:0] val,
                             input bit vld, input logic [XLEN-1:0] mask);
    @(negedge clk);
    exp_wr_en  = 1'b1;
    exp_wr_idx = IDX_W'(idx);
    exp_wr_reg = 5'(rnum);
    exp_wr_val = val;
    exp_wr_vld = vld;
`ifdef RESULT_CHECK_MASK_EN
    exp_wr_mask = mask;
    m_mask[idx] = mask;
`else
    m_mask[idx] = '1;
    if (mask == '0) m_mask[idx] = '1;
`endif
    @(negedge clk);
    exp_wr_en = 1'b0;
    m_vld[idx]  = vld;
    m_rnum[idx] = 5'(rnum);
    m_val[idx]  = val;
  endtask

  // One full run from start pulse to DONE, compared against expectations.
  task automatic do_run(input string name, input int exp_len, input bit exp_to, input bit noise);
    int c, c_done, busy_err, addr_err, fc, fi;
    logic [XLEN-1:0] fv;
    logic [4:0] exp_addr;
    model_expect(fc, fi, fv);
    @(negedge clk);
    start = 1'b1;
    pc_in = pc_seq[0];
    c = 0; c_done = -1; busy_err = 0; addr_err = 0;
    while (c_done < 0 && c < 200) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      exp_wr_en = 1'b0;
      if (done) begin
        c_done = c;
      end else begin
        if (c <= exp_len + NUM_CHECKS && !busy) busy_err++;
        exp_addr = (c > exp_len && c <= exp_len + NUM_CHECKS) ? m_rnum[c-exp_len-1] : 5'd0;
        if (c <= exp_len + NUM_CHECKS && rf_rd_addr !== exp_addr) addr_err++;
        pc_in = pc_seq[c];
        if (noise && c <= exp_len + NUM_CHECKS) begin
          start      = ($urandom_range(0, 2) == 0);
          exp_wr_en  = ($urandom_range(0, 2) == 0);
          exp_wr_idx = IDX_W'($urandom_range(0, NUM_CHECKS - 1));
          exp_wr_reg = 5'($urandom_range(0, 31));
          exp_wr_val = $urandom;
          exp_wr_vld = 1'b1;
        end
      end
    end
    start = 1'b0;
    exp_wr_en = 1'b0;
    chk({name, " done_latency"}, 64'(c_done), 64'(exp_len + NUM_CHECKS + 1));
    chk({name, " busy_window"}, 64'(busy_err), 64'd0);
    chk({name, " rd_addr_seq"}, 64'(addr_err), 64'd0);
    chk({name, " timed_out"}, 64'(timed_out), 64'(exp_to));
    chk({name, " pass"}, 64'(pass), 64'(fc == 0));
    chk({name, " fail_count"}, 64'(fail_count), 64'(fc));
    chk({name, " first_fail_idx"}, 64'(first_fail_idx), 64'(fi));
    chk({name, " first_fail_val"}, 64'(first_fail_val), 64'(fv));
    repeat (2) @(negedge clk);
    chk({name, " done_hold"}, {59'd0, done, fail_count}, {59'd0, 1'b1, 4'(fc)});
    $display("run %s: len=%0d timed_out=%0b pass=%0b fail_count=%0d", name, exp_len, exp_to, pass, fail_count);
  endtask

  pc_vec_t vecs [7];

  initial begin
    int len;
    bit to;
    rf[0] = '0;
    for (int j = 1; j < 32; j++) rf[j] = $urandom;
    rf[10] = 32'd1; rf[11] = 32'd2; rf[12] = 32'd3;
    rf[5] = 32'h1234_00FF;
    model_clear();

    vecs[0] = '{a: 4, inc: 0,   exp_len: 3,  exp_to: 1'b0};
    vecs[1] = '{a: 3, inc: 0,   exp_len: 6,  exp_to: 1'b0};
    vecs[2] = '{a: 2, inc: 0,   exp_len: 5,  exp_to: 1'b0};
    vecs[3] = '{a: 1, inc: 100, exp_len: 20, exp_to: 1'b1};
    vecs[4] = '{a: 1, inc: 16,  exp_len: 20, exp_to: 1'b0};
    vecs[5] = '{a: 1, inc: 17,  exp_len: 20, exp_to: 1'b1};
    vecs[6] = '{a: 1, inc: 10,  exp_len: 14, exp_to: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'd0, busy, done, pass, timed_out, fail_count, first_fail_idx,
                          first_fail_val, rf_rd_addr}, 64'd0);
    resetn = 1'b1;

    write_entry(0, 10, 32'd1, 1'b1, '1);
    write_entry(1, 11, 32'd2, 1'b1, '1);
    write_entry(2, 12, 32'd3, 1'b1, '1);
    fill_pc(1, 10);
    do_run("branch_halt", 14, 1'b0, 1'b0);
    chk("branch_halt pass_const", 64'(pass), 64'd1);

    write_entry(1, 11, 32'd5, 1'b1, '1);
    do_run("x11_mismatch", 14, 1'b0, 1'b0);
    chk("x11_mismatch idx_const", 64'(first_fail_idx), 64'd1);
    chk("x11_mismatch val_const", 64'(first_fail_val), 64'd2);
    write_entry(1, 11, 32'd2, 1'b1, '1);

    for (int v = 0; v < 7; v++) begin
      fill_pc(vecs[v].a, vecs[v].inc);
      do_run($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].exp_to, 1'b0);
    end

    // Reset in the middle of CHECK with a failing entry loaded.
    write_entry(1, 11, 32'd5, 1'b1, '1);
    fill_pc(4, 0);
    @(negedge clk);
    start = 1'b1;
    pc_in = pc_seq[0];
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      pc_in = pc_seq[c];
    end
    chk("rst_mid_check busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_check outputs", {16'd0, busy, done, pass, timed_out, fail_count, first_fail_idx,
                                  first_fail_val, rf_rd_addr}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
    do_run("empty_table", 3, 1'b0, 1'b0);
    chk("empty_table pass_const", 64'(pass), 64'd1);

    write_entry(0, 5, 32'h0000_00FF, 1'b1, 32'h0000_00FF);
    do_run("mask", 3, 1'b0, 1'b0);
`ifdef RESULT_CHECK_MASK_EN
    chk("mask fail_const", 64'(fail_count), 64'd0);
`else
    chk("mask fail_const", 64'(fail_count), 64'd1);
`endif

    for (int r = 0; r < 15; r++) begin
      for (int j = 0; j < NUM_CHECKS; j++) begin
        int rn;
        rn = $urandom_range(1, 31);
        write_entry(j, rn, ($urandom_range(0, 1) == 1) ? rf[rn] : $urandom,
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom);
      end
      fill_pc($urandom_range(1, 6), $urandom_range(0, 24));
      model_run(len, to);
      do_run($sformatf("rand%0d", r), len, to, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
